// File: rtl/hdmi_out_pkg.sv
// Shared types and constants for the hdmi_out line path. The default data
// width and burst limit are also used by fill_fifo_fsm.
package hdmi_out_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_BURST_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } fetch_state_e;

  // Bytes carried by one memory beat.
  function automatic int calc_beat_b(input int data_w);
    return data_w / 8;
  endfunction

  // Width of a burst length field able to hold 1..burst_max.
  function automatic int calc_len_w(input int burst_max);
    return $clog2(burst_max) + 1;
  endfunction

endpackage

// File: rtl/hdmi_burst_sizer.sv
// Burst sizing for the line fetcher: picks the next burst length from the
// remaining beat count and precomputes the remaining count and start
// address that follow once that burst has been consumed.
module hdmi_burst_sizer #(
  parameter int ADDR_W    = 32,
  parameter int BURST_MAX = 16,
  parameter int BEAT_B    = 4,
  parameter int LEN_W     = 5,
  parameter int BL_W      = 16
) (
  input  logic [BL_W-1:0]   beats_left_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [LEN_W-1:0]  cur_len_o,
  output logic [BL_W-1:0]   next_beats_left_o,
  output logic [ADDR_W-1:0] next_addr_o
);

  assign cur_len_o = (beats_left_i >= BL_W'(BURST_MAX)) ? LEN_W'(BURST_MAX)
                                                        : beats_left_i[LEN_W-1:0];

  assign next_beats_left_o = beats_left_i - BL_W'(cur_len_o);

  // Address arithmetic wraps modulo 2^ADDR_W by construction.
  assign next_addr_o = addr_i + ADDR_W'(cur_len_o) * ADDR_W'(BEAT_B);

endmodule

// File: rtl/hdmi_line_fetch.sv
// Line fetcher for the hdmi_out pcore: on each go_fill_fifo pulse, reads one
// display line from DDR2 as a series of bounded bursts (one outstanding) and
// pushes the returned beats into the pixel line FIFO.
// Optional build macro HDMI_FETCH_BSWAP_EN: reverse byte order within each
// 32-bit lane on the way into the FIFO (no added latency).
module hdmi_line_fetch
  import hdmi_out_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = 32,
  parameter int BURST_MAX = DEF_BURST_MAX,
  parameter int FIFO_AW   = 9,
  localparam int LEN_W    = calc_len_w(BURST_MAX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go_fill_fifo,
  input  logic [ADDR_W-1:0] ddr_addr_to_read,
  input  logic [15:0]       line_bytes,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [LEN_W-1:0]  mem_rd_len,
  input  logic              mem_rd_ack,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              fifo_wr_en,
  output logic [DATA_W-1:0] fifo_wr_data,
  input  logic [FIFO_AW:0]  fifo_free,
  output logic              busy,
  output logic              line_done,
  output logic              go_dropped
);

  localparam int BEAT_B = calc_beat_b(DATA_W);
  localparam int BL_W   = 16;
  localparam int BR_W   = BL_W + 1;
  localparam int FREE_W = FIFO_AW + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [BL_W-1:0]   beats_left_q, beats_left_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              req_q, req_d;
  logic              busy_q;
  logic              line_done_q, line_done_d;
  logic              go_dropped_q, go_dropped_d;

  logic [LEN_W-1:0]  cur_len;
  logic [BL_W-1:0]   next_beats_left;
  logic [ADDR_W-1:0] next_addr;
  logic [BR_W-1:0]   line_bytes_rnd;
  logic [BL_W-1:0]   line_beats;
  logic              go_accept;
  logic              last_beat;

  hdmi_burst_sizer #(
    .ADDR_W    (ADDR_W),
    .BURST_MAX (BURST_MAX),
    .BEAT_B    (BEAT_B),
    .LEN_W     (LEN_W),
    .BL_W      (BL_W)
  ) u_sizer (
    .beats_left_i      (beats_left_q),
    .addr_i            (addr_q),
    .cur_len_o         (cur_len),
    .next_beats_left_o (next_beats_left),
    .next_addr_o       (next_addr)
  );

  // Line length in beats, rounded up so a partial final beat is still fetched.
  assign line_bytes_rnd = {1'b0, line_bytes} + BR_W'(BEAT_B - 1);
  assign line_beats     = BL_W'(line_bytes_rnd / BR_W'(BEAT_B));

  // A go that lands while busy, or on the line_done cycle, is dropped.
  assign go_accept    = go_fill_fifo && (state_q == IDLE) && !line_done_q;
  assign go_dropped_d = go_fill_fifo && !go_accept;
  assign last_beat    = (beat_cnt_q + LEN_W'(1)) == cur_len;

  // Next-state logic: capture, request handshake and beat counting.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    addr_d       = addr_q;
    beats_left_d = beats_left_q;
    beat_cnt_d   = beat_cnt_q;
    req_d        = 1'b0;
    line_done_d  = 1'b0;
    fifo_wr_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_accept) begin
          addr_d       = ddr_addr_to_read;
          beats_left_d = line_beats;
          beat_cnt_d   = '0;
          if (line_beats == '0) line_done_d = 1'b1;
          else                  state_d     = REQ;
        end
      end
      REQ: begin
        // Once raised, req is held until accepted; free space only grows
        // while this block has no burst in flight.
        if (req_q && mem_rd_ack) state_d = DATA;
        else req_d = req_q || (fifo_free >= FREE_W'(cur_len));
      end
      DATA: begin
        if (mem_rd_valid) begin
          fifo_wr_en = 1'b1;
          if (last_beat) begin
            beat_cnt_d   = '0;
            addr_d       = next_addr;
            beats_left_d = next_beats_left;
            if (next_beats_left == '0) begin
              state_d     = IDLE;
              line_done_d = 1'b1;
            end else begin
              state_d = REQ;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      beats_left_q <= '0;
      beat_cnt_q   <= '0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      line_done_q  <= 1'b0;
      go_dropped_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      beats_left_q <= beats_left_d;
      beat_cnt_q   <= beat_cnt_d;
      req_q        <= req_d;
      busy_q       <= (state_d != IDLE);
      line_done_q  <= line_done_d;
      go_dropped_q <= go_dropped_d;
    end
  end

  // FIFO data path: straight through, or byte-reversed per 32-bit lane.
  always_comb begin
    fifo_wr_data = mem_rd_data;
`ifdef HDMI_FETCH_BSWAP_EN
    for (int lane = 0; lane < DATA_W / 32; lane++) begin
      for (int b = 0; b < 4; b++) begin
        fifo_wr_data[lane*32 + b*8 +: 8] = mem_rd_data[lane*32 + (3-b)*8 +: 8];
      end
    end
`endif
  end

  assign mem_rd_req  = req_q;
  assign mem_rd_addr = addr_q;
  assign mem_rd_len  = cur_len;
  assign busy        = busy_q;
  assign line_done   = line_done_q;
  assign go_dropped  = go_dropped_q;

endmodule

// File: tb/tb_hdmi_line_fetch.sv
// Self-checking bench for hdmi_line_fetch: table of whole-line fetches plus
// hand-written sequences for zero-length lines, FIFO backpressure, reset in
// the middle of a burst and the optional byte swap (HDMI_FETCH_BSWAP_EN).
module tb_hdmi_line_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        go_fill_fifo;
  logic [31:0] ddr_addr_to_read;
  logic [15:0] line_bytes;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic [4:0]  mem_rd_len;
  logic        mem_rd_ack;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        fifo_wr_en;
  logic [31:0] fifo_wr_data;
  logic [9:0]  fifo_free;
  logic        busy;
  logic        line_done;
  logic        go_dropped;

  hdmi_line_fetch #(
    .DATA_W    (32),
    .ADDR_W    (32),
    .BURST_MAX (16),
    .FIFO_AW   (9)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .go_fill_fifo     (go_fill_fifo),
    .ddr_addr_to_read (ddr_addr_to_read),
    .line_bytes       (line_bytes),
    .mem_rd_req       (mem_rd_req),
    .mem_rd_addr      (mem_rd_addr),
    .mem_rd_len       (mem_rd_len),
    .mem_rd_ack       (mem_rd_ack),
    .mem_rd_valid     (mem_rd_valid),
    .mem_rd_data      (mem_rd_data),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_data     (fifo_wr_data),
    .fifo_free        (fifo_free),
    .busy             (busy),
    .line_done        (line_done),
    .go_dropped       (go_dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bytes;
    logic [31:0] addr;
    int          hold;       // cycles ack is withheld per burst
    int          go_at;      // serve cycle for an extra go pulse, -1 none
    int          bursts;
    logic [4:0]  first_len;
    logic [4:0]  last_len;
    logic [31:0] last_addr;
    int          writes;
    int          drops;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          wr_cnt = 0;
  int          done_cnt = 0;
  int          drop_cnt = 0;
  logic [31:0] hs_addr[$];
  logic [4:0]  hs_len[$];
  logic        req_prev = 1'b0;
  logic        hs_prev = 1'b0;
  logic [31:0] addr_prev = '0;
  logic [4:0]  len_prev = '0;
  logic [31:0] data_ctr = 32'h1122_3345;
  vec_t        vecs[7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [31:0] d);
`ifdef HDMI_FETCH_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  // One clock: sample at the falling edge, return 1 time unit after the
  // next rising edge so the caller can drive inputs for the following cycle.
  task automatic tick();
    logic hs;
    @(negedge clk);
    if (fifo_wr_en) begin
      wr_cnt++;
      check("wr_data", 64'(fifo_wr_data), 64'(exp_data(mem_rd_data)));
    end
    if (line_done) begin
      done_cnt++;
      check("busy_low_with_done", 64'(busy), 64'd0);
    end
    if (go_dropped) drop_cnt++;
    if (mem_rd_req && req_prev && !hs_prev) begin
      check("addr_stable", 64'(mem_rd_addr), 64'(addr_prev));
      check("len_stable", 64'(mem_rd_len), 64'(len_prev));
    end
    hs = mem_rd_req && mem_rd_ack;
    if (hs) begin
      hs_addr.push_back(mem_rd_addr);
      hs_len.push_back(mem_rd_len);
    end
    req_prev  = mem_rd_req;
    hs_prev   = hs;
    addr_prev = mem_rd_addr;
    len_prev  = mem_rd_len;
    @(posedge clk);
    #1;
  endtask

  task automatic start_line(input logic [31:0] a, input logic [15:0] n);
    go_fill_fifo     = 1'b1;
    ddr_addr_to_read = a;
    line_bytes       = n;
    tick();
    go_fill_fifo = 1'b0;
  endtask

  // Memory model: ack after `hold` cycles, data 2 cycles after the ack cycle.
  task automatic serve(input int hold, input int go_at);
    int ms, len, beat, hold_left, start_done, cycles;
    ms = 0; len = 0; beat = 0; hold_left = hold; cycles = 0;
    start_done = done_cnt;
    while (done_cnt == start_done && cycles < 3000) begin
      go_fill_fifo = (cycles == go_at);
      if (go_fill_fifo) begin
        ddr_addr_to_read = 32'hDEAD_0000;
        line_bytes       = 16'd4;
      end
      case (ms)
        0: begin
          mem_rd_valid = 1'b0;
          mem_rd_ack   = 1'b0;
          if (mem_rd_req) begin
            if (hold_left > 0) hold_left--;
            else begin
              mem_rd_ack = 1'b1;
              len = int'(mem_rd_len);
              ms  = 1;
            end
          end
        end
        1: begin
          mem_rd_ack = 1'b0;
          beat = 0;
          hold_left = hold;
          ms = 2;
        end
        default: begin
          if (beat < len) begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = data_ctr;
            data_ctr     = data_ctr + 32'h0102_0304;
            beat++;
          end else begin
            mem_rd_valid = 1'b0;
            ms = 0;
          end
        end
      endcase
      tick();
      cycles++;
    end
    go_fill_fifo = 1'b0;
    mem_rd_ack   = 1'b0;
    mem_rd_valid = 1'b0;
    check("line_done_once", 64'(done_cnt - start_done), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int s_wr, s_hs, s_drop, n;
    logic [31:0] fa, la;
    logic [4:0]  fl, ll;
    s_wr = wr_cnt; s_hs = hs_addr.size(); s_drop = drop_cnt;
    start_line(v.addr, v.bytes);
    serve(v.hold, v.go_at);
    n  = hs_addr.size() - s_hs;
    fa = (n > 0) ? hs_addr[s_hs] : '0;
    fl = (n > 0) ? hs_len[s_hs] : '0;
    la = (n > 0) ? hs_addr[hs_addr.size()-1] : '0;
    ll = (n > 0) ? hs_len[hs_len.size()-1] : '0;
    check({tag, ".bursts"}, 64'(n), 64'(v.bursts));
    check({tag, ".first_addr"}, 64'(fa), 64'(v.addr));
    check({tag, ".first_len"}, 64'(fl), 64'(v.first_len));
    check({tag, ".last_addr"}, 64'(la), 64'(v.last_addr));
    check({tag, ".last_len"}, 64'(ll), 64'(v.last_len));
    check({tag, ".writes"}, 64'(wr_cnt - s_wr), 64'(v.writes));
    check({tag, ".drops"}, 64'(drop_cnt - s_drop), 64'(v.drops));
    check({tag, ".busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int s_wr, s_hs, s_drop, n;
    logic seen;
    logic [31:0] swap_exp;

    vecs[0] = '{16'd2560, 32'h1000_0000, 0, -1, 40, 5'd16, 5'd16, 32'h1000_09C0, 640, 0};
    vecs[1] = '{16'd100,  32'h2000_0000, 0, -1, 2,  5'd16, 5'd9,  32'h2000_0040, 25,  0};
    vecs[2] = '{16'd2,    32'h3000_0010, 0, -1, 1,  5'd1,  5'd1,  32'h3000_0010, 1,   0};
    vecs[3] = '{16'd128,  32'hFFFF_FFC0, 0, -1, 2,  5'd16, 5'd16, 32'h0000_0000, 32,  0};
    vecs[4] = '{16'd65,   32'h4000_0004, 0, -1, 2,  5'd16, 5'd1,  32'h4000_0044, 17,  0};
    vecs[5] = '{16'd100,  32'h5000_0000, 0, 5,  2,  5'd16, 5'd9,  32'h5000_0040, 25,  1};
    vecs[6] = '{16'd64,   32'h7000_0000, 5, -1, 1,  5'd16, 5'd16, 32'h7000_0000, 16,  0};

    reset = 1'b1; go_fill_fifo = 1'b0; ddr_addr_to_read = '0; line_bytes = '0;
    mem_rd_ack = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0; fifo_free = 10'd512;
    #1;
    check("rst.req", 64'(mem_rd_req), 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.addr", 64'(mem_rd_addr), 64'd0);
    check("rst.len", 64'(mem_rd_len), 64'd0);
    check("rst.line_done", 64'(line_done), 64'd0);
    check("rst.go_dropped", 64'(go_dropped), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Zero-length line: done next cycle, no request; go on the done cycle drops.
    s_hs = hs_addr.size(); s_drop = drop_cnt;
    start_line(32'h8000_0000, 16'd0);
    check("zero.line_done", 64'(line_done), 64'd1);
    check("zero.busy", 64'(busy), 64'd0);
    check("zero.req", 64'(mem_rd_req), 64'd0);
    go_fill_fifo = 1'b1; line_bytes = 16'd4;
    tick();
    go_fill_fifo = 1'b0;
    check("zero.line_done_clear", 64'(line_done), 64'd0);
    check("zero.go_dropped", 64'(go_dropped), 64'd1);
    check("zero.busy_after_drop", 64'(busy), 64'd0);
    tick();
    check("zero.req_after", 64'(mem_rd_req), 64'd0);
    check("zero.no_bursts", 64'(hs_addr.size() - s_hs), 64'd0);
    check("zero.drop_cnt", 64'(drop_cnt - s_drop), 64'd1);

    // Backpressure: 10 free entries cannot take a 16-beat burst.
    s_wr = wr_cnt; s_hs = hs_addr.size();
    fifo_free = 10'd10;
    start_line(32'h9000_0000, 16'd64);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen = seen | mem_rd_req;
    end
    check("bp.req_held_low", 64'(seen), 64'd0);
    check("bp.busy", 64'(busy), 64'd1);
    fifo_free = 10'd16;
    tick();
    check("bp.req_up", 64'(mem_rd_req), 64'd1);
    check("bp.len", 64'(mem_rd_len), 64'd16);
    check("bp.addr", 64'(mem_rd_addr), 64'h9000_0000);
    serve(5, -1);
    fifo_free = 10'd512;
    check("bp.bursts", 64'(hs_addr.size() - s_hs), 64'd1);
    check("bp.writes", 64'(wr_cnt - s_wr), 64'd16);

    // Reset after beat 7 of a burst, then stray beats, then a clean line.
    s_wr = wr_cnt;
    start_line(32'hA000_0000, 16'd64);
    n = 0;
    while (!mem_rd_req && n < 10) begin tick(); n++; end
    check("rst_mid.req_seen", 64'(mem_rd_req), 64'd1);
    mem_rd_ack = 1'b1;
    tick();
    mem_rd_ack = 1'b0;
    tick();
`ifdef HDMI_FETCH_BSWAP_EN
    swap_exp = 32'hDDCC_BBAA;
`else
    swap_exp = 32'hAABB_CCDD;
`endif
    for (int b = 0; b < 7; b++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = (b == 0) ? 32'hAABB_CCDD : data_ctr + 32'(b);
      if (b == 0) begin
        #1;
        check("bswap", 64'(fifo_wr_data), 64'(swap_exp));
        check("wr_en_comb", 64'(fifo_wr_en), 64'd1);
      end
      tick();
    end
    check("rst_mid.writes_before", 64'(wr_cnt - s_wr), 64'd7);
    reset = 1'b1;
    #1;
    check("rst_mid.req", 64'(mem_rd_req), 64'd0);
    check("rst_mid.busy", 64'(busy), 64'd0);
    check("rst_mid.addr", 64'(mem_rd_addr), 64'd0);
    check("rst_mid.len", 64'(mem_rd_len), 64'd0);
    check("rst_mid.wr_en", 64'(fifo_wr_en), 64'd0);
    check("rst_mid.line_done", 64'(line_done), 64'd0);
    tick(); tick();
    reset = 1'b0;
    s_hs = hs_addr.size();
    for (int b = 0; b < 4; b++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = 32'h5555_0000 + 32'(b);
      tick();
    end
    mem_rd_valid = 1'b0;
    check("stray.writes", 64'(wr_cnt - s_wr), 64'd7);
    check("stray.no_req", 64'(hs_addr.size() - s_hs), 64'd0);
    check("stray.busy", 64'(busy), 64'd0);
    run_vec('{16'd100, 32'hB000_0000, 0, -1, 2, 5'd16, 5'd9, 32'hB000_0040, 25, 0}, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
